fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage.
- Drives the PC onto the instruction-memory address bus and assembles one- or two-word instructions; a two-word instruction carries a 16-bit immediate in its second word.
- Presents a complete instruction, its immediate, return PC and valid flag to decode.
- Honours stall from the hazard unit and flush/redirect on taken branches.

---
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID register outputs of the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [INSTR_WIDTH-1:0] if_id_imm;
  logic [PC_WIDTH-1:0]    if_id_pc_next;
  logic                   if_id_valid;

  // Fetch stage side: drives the address and the IF/ID register.
  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_id_instr,
    output if_id_imm,
    output if_id_pc_next,
    output if_id_valid
  );

  // Memory / decode side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_id_instr,
    input  if_id_imm,
    input  if_id_pc_next,
    input  if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Assembles one- or two-word instructions; word bit [INSTR_WIDTH-1] set in
// the opcode slot marks a two-word instruction whose second word is the
// immediate. Branch redirect beats stall, stall beats normal fetch.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter int unsigned         INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  fetch_stage_if.master       bus
);

  typedef enum logic {
    FETCH_OP,
    FETCH_IMM
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [INSTR_WIDTH-1:0] hold;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] imm_q;
  logic [PC_WIDTH-1:0]    pc_next_q;
  logic                   valid_q;

  // PC is driven straight from the register: no path from stall/branch.
  assign bus.imem_addr     = pc;
  assign bus.if_id_instr   = instr_q;
  assign bus.if_id_imm     = imm_q;
  assign bus.if_id_pc_next = pc_next_q;
  assign bus.if_id_valid   = valid_q;

  // Sequential PC successor; wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_inc = pc + PC_WIDTH'(1);
  end

  // Fetch FSM, PC, hold word and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH_OP;
      pc        <= RESET_VECTOR;
      hold      <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (branch_taken) begin
      state     <= FETCH_OP;
      pc        <= branch_target;
      hold      <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (!stall) begin
      pc <= pc_inc;
      unique case (state)
        FETCH_OP: begin
          if (bus.imem_rdata[INSTR_WIDTH-1]) begin
            hold    <= bus.imem_rdata;
            state   <= FETCH_IMM;
            instr_q <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
          end else begin
            instr_q   <= bus.imem_rdata;
            imm_q     <= '0;
            pc_next_q <= pc_inc;
            valid_q   <= 1'b1;
          end
        end
        FETCH_IMM: begin
          instr_q   <= hold;
          imm_q     <= bus.imem_rdata;
          pc_next_q <= pc_inc;
          valid_q   <= 1'b1;
          state     <= FETCH_OP;
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors with literal
// expectations plus an instruction-level reference model compared each cycle.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] mem [0:65535];

  int unsigned tests;
  int unsigned fails;

  fetch_stage_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus ();

  assign bus.imem_rdata = mem[bus.imem_addr];

  fetch_stage #(
    .PC_WIDTH    (16),
    .INSTR_WIDTH (16),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the PC and where the instruction in progress
  // started; a completed two-word instruction is rebuilt from memory.
  logic [15:0] m_pc, m_start, m_instr, m_imm, m_pcn;
  logic        m_mid, m_valid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 16'h0000; m_start <= 16'h0000; m_mid <= 1'b0;
      m_instr <= 16'h0; m_imm <= 16'h0; m_pcn <= 16'h0; m_valid <= 1'b0;
    end else if (branch_taken) begin
      m_pc <= branch_target; m_mid <= 1'b0;
      m_instr <= 16'h0; m_imm <= 16'h0; m_pcn <= 16'h0; m_valid <= 1'b0;
    end else if (!stall) begin
      m_pc <= m_pc + 16'd1;
      if (m_mid) begin
        m_instr <= mem[m_start]; m_imm <= mem[m_pc];
        m_pcn <= m_pc + 16'd1; m_valid <= 1'b1; m_mid <= 1'b0;
      end else if (mem[m_pc] >= 16'h8000) begin
        m_start <= m_pc; m_mid <= 1'b1;
        m_instr <= 16'h0; m_imm <= 16'h0; m_valid <= 1'b0;
      end else begin
        m_instr <= mem[m_pc]; m_imm <= 16'h0;
        m_pcn <= m_pc + 16'd1; m_valid <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_addr",    bus.imem_addr,      m_pc);
      chk("m_valid",   {15'd0, bus.if_id_valid}, {15'd0, m_valid});
      chk("m_instr",   bus.if_id_instr,    m_instr);
      chk("m_imm",     bus.if_id_imm,      m_imm);
      chk("m_pc_next", bus.if_id_pc_next,  m_pcn);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input logic [15:0] addr, input logic v,
                     input logic [15:0] instr, input logic [15:0] imm, input logic [15:0] pcn);
    chk({tag, "_addr"},  bus.imem_addr, addr);
    chk({tag, "_valid"}, {15'd0, bus.if_id_valid}, {15'd0, v});
    chk({tag, "_instr"}, bus.if_id_instr, instr);
    chk({tag, "_imm"},   bus.if_id_imm, imm);
    chk({tag, "_pcn"},   bus.if_id_pc_next, pcn);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1471;
    mem[16'h0001] = 16'h0C22;
    mem[16'h0002] = 16'h8530;
    mem[16'h0003] = 16'hFFFF;
    mem[16'h0005] = 16'h9000;
    mem[16'h0040] = 16'h0ABC;
    mem[16'hFFFF] = 16'h8001;

    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    #1;
    lit("reset", 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0);
    step(); step();
    rst = 1'b1;

    // One-word stream.
    step(); lit("ow0", 16'h0001, 1'b1, 16'h1471, 16'h0, 16'h0001);
    step(); lit("ow1", 16'h0002, 1'b1, 16'h0C22, 16'h0, 16'h0002);
    // Two-word: bubble, then stall three cycles in the immediate fetch.
    step(); lit("tw_bub", 16'h0003, 1'b0, 16'h0, 16'h0, 16'h0002);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); lit("stall", 16'h0003, 1'b0, 16'h0, 16'h0, 16'h0002);
    end
    stall = 1'b0;
    step(); lit("tw_done", 16'h0004, 1'b1, 16'h8530, 16'hFFFF, 16'h0004);
    step(); lit("ow4", 16'h0005, 1'b1, 16'h0000, 16'h0, 16'h0005);
    // Enter the immediate fetch of 0x9000, then branch while stalled.
    step(); lit("tw2_bub", 16'h0006, 1'b0, 16'h0, 16'h0, 16'h0005);
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    step(); lit("redir", 16'h0040, 1'b0, 16'h0, 16'h0, 16'h0);
    branch_taken = 1'b0; stall = 1'b0;
    step(); lit("tgt", 16'h0041, 1'b1, 16'h0ABC, 16'h0, 16'h0041);
    // Wrap-around two-word instruction at FFFF.
    mem[16'h0000] = 16'h1234;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step(); lit("wrap_br", 16'hFFFF, 1'b0, 16'h0, 16'h0, 16'h0);
    branch_taken = 1'b0;
    step(); lit("wrap_bub", 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0);
    step(); lit("wrap", 16'h0001, 1'b1, 16'h8001, 16'h1234, 16'h0001);

    // Asynchronous reset mid-run, observed before any clock edge.
    rst = 1'b0;
    #1;
    lit("async_rst", 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0);
    step();
    rst = 1'b1;
    step(); lit("post_rst", 16'h0001, 1'b1, 16'h1234, 16'h0, 16'h0001);

    // Mixed code with periodic stalls and branches, checked by the model.
    for (int unsigned a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 80; i++) begin
      stall = ((i % 7) == 3);
      branch_taken = ((i % 13) == 6);
      branch_target = 16'(i * 37);
      step();
    end
    stall = 1'b0; branch_taken = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
